// File: rtl/strobe_cmp_reg_pkg.sv
// Constants and types shared by the tester compare path and pin driver.
package strobe_cmp_reg_pkg;

    localparam int unsigned EDGE_W     = 7;
    localparam int unsigned CYCLE_W    = 8;
    localparam int unsigned FAIL_CNT_W = 16;

    typedef struct packed {
        logic exp_val;
        logic mask;
    } vec_t;

    function automatic logic [FAIL_CNT_W-1:0] sat_inc(input logic [FAIL_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/strobe_cmp_reg_cycle_timer.sv
// Tester cycle timer: counts ticks per cycle and flags the strobe tick.
module cycle_timer
    import strobe_cmp_reg_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [CYCLE_W-1:0] cycle_len,
    input  logic [EDGE_W-1:0]  strobe_edge,
    output logic               strobe
);

    logic [CYCLE_W-1:0] tick;
    logic [CYCLE_W-1:0] tick_inc;
    logic [CYCLE_W-1:0] tick_next;
    logic [CYCLE_W-1:0] edge_ext;

    // tick_inc >= cycle_len also covers lengths of 0 and 1, which pin the timer at 0
    always_comb begin
        tick_inc  = tick + 1'b1;
        edge_ext  = CYCLE_W'(strobe_edge);
        tick_next = (!en || (tick_inc >= cycle_len)) ? '0 : tick_inc;
        strobe    = en && (tick == edge_ext) && (edge_ext < cycle_len);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick <= '0;
        end else begin
            tick <= tick_next;
        end
    end

endmodule

// File: rtl/strobe_cmp_reg.sv
// Strobed pin comparator with buffer/active vector stages and fail accounting.
module strobe_cmp_reg
    import strobe_cmp_reg_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN_CMP_LOGIC,
    input  logic                  LOAD,
    input  logic                  TRANSFER,
    input  logic                  EXPECT,
    input  logic                  MASK,
    input  logic [EDGE_W-1:0]     STROBE_EDGE_1,
    input  logic [EDGE_W-1:0]     STROBE_EDGE_2,
    input  logic [CYCLE_W-1:0]    CYCLE_LENGTH_1,
    input  logic                  TEST_CYCLE,
    input  logic                  CLR_FAIL,
    input  logic                  DUT_IN,
    output logic                  VALID,
    output logic                  FAIL,
    output logic                  CAPTURED,
    output logic                  FAIL_STICKY,
    output logic [FAIL_CNT_W-1:0] FAIL_COUNT
);

    vec_t              buf_stage;
    vec_t              act_stage;
    logic [EDGE_W-1:0] sel_edge;
    logic              strobe;
    logic              fail_now;

    assign sel_edge = TEST_CYCLE ? STROBE_EDGE_2 : STROBE_EDGE_1;

    cycle_timer u_timer (
        .clk         (CLK),
        .rst         (RST),
        .en          (EN_CMP_LOGIC),
        .cycle_len   (CYCLE_LENGTH_1),
        .strobe_edge (sel_edge),
        .strobe      (strobe)
    );

    assign fail_now = strobe && !act_stage.mask && (DUT_IN != act_stage.exp_val);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            buf_stage <= '0;
            act_stage <= '0;
        end else if (LOAD) begin
            buf_stage <= '{exp_val: EXPECT, mask: MASK};
        end else if (TRANSFER) begin
            act_stage <= buf_stage;
        end
    end

    // Fail accounting moves on the same edge that raises FAIL, so a clear
    // coinciding with a fail leaves exactly that one fail recorded.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            VALID       <= 1'b0;
            FAIL        <= 1'b0;
            CAPTURED    <= 1'b0;
            FAIL_STICKY <= 1'b0;
            FAIL_COUNT  <= '0;
        end else begin
            VALID <= strobe;
            FAIL  <= fail_now;
            if (strobe) begin
                CAPTURED <= DUT_IN;
            end
            if (CLR_FAIL) begin
                FAIL_STICKY <= fail_now;
                FAIL_COUNT  <= fail_now ? FAIL_CNT_W'(1) : '0;
            end else if (fail_now) begin
                FAIL_STICKY <= 1'b1;
                FAIL_COUNT  <= sat_inc(FAIL_COUNT);
            end
        end
    end

endmodule

// File: doc/strobe_cmp_reg.md
STROBE_CMP_REG -- requirements
Module: strobe_cmp_reg

Interface
REQ-001 CLK  input  1  sole clock; all state updates on rising edge.
REQ-002 RST  input  1  reset, asynchronous, active-high.
REQ-003 EN_CMP_LOGIC  input  1  enables the cycle timer and compare; low holds the timer at 0 and suppresses strobes.
REQ-004 LOAD  input  1  loads EXPECT and MASK into the buffer stage.
REQ-005 TRANSFER  input  1  copies the buffer stage into the active stage.
REQ-006 EXPECT  input  1  expected DUT pin value for the vector.
REQ-007 MASK  input  1  1 = don't-care; compare suppressed for the vector.
REQ-008 STROBE_EDGE_1  input  7  strobe tick in a normal cycle.
REQ-009 STROBE_EDGE_2  input  7  strobe tick when TEST_CYCLE=1.
REQ-010 CYCLE_LENGTH_1  input  8  ticks per tester cycle.
REQ-011 TEST_CYCLE  input  1  selects STROBE_EDGE_2 over STROBE_EDGE_1, combinationally.
REQ-012 CLR_FAIL  input  1  synchronous clear of FAIL_STICKY and FAIL_COUNT.
REQ-013 DUT_IN  input  1  DUT pin value, synchronous to CLK.
REQ-014 VALID  output  1  one-clock pulse; a compare was evaluated.
REQ-015 FAIL  output  1  one-clock pulse; coincident with VALID on a mismatch.
REQ-016 CAPTURED  output  1  DUT_IN value taken at the last strobe.
REQ-017 FAIL_STICKY  output  1  set by any FAIL; cleared only by RST/CLR_FAIL.
REQ-018 FAIL_COUNT  output  16  number of FAIL pulses, saturating.

Function
REQ-019 Timer counts 0..CYCLE_LENGTH_1-1 while EN_CMP_LOGIC=1, then wraps to 0; CYCLE_LENGTH_1 of 0 or 1 holds it at 0.
REQ-020 EN_CMP_LOGIC low forces the timer to 0 on the next edge; counting restarts from 0 on re-enable.
REQ-021 Strobe event: EN_CMP_LOGIC=1 and timer == selected strobe edge; an edge >= CYCLE_LENGTH_1 produces no strobe.
REQ-022 On the strobe edge, CAPTURED <= DUT_IN; VALID=1 for the following clock; latency 1 clock.
REQ-023 FAIL=1 with VALID iff active mask=0 and DUT_IN != active expect at the strobe edge.
REQ-024 Masked strobe: VALID pulses, FAIL=0, CAPTURED still updates.
REQ-025 LOAD has priority over TRANSFER; when both are high, only LOAD takes effect.
REQ-026 TRANSFER on the strobe edge: the compare uses the pre-transfer active values; the new values apply from the next edge.
REQ-027 FAIL_COUNT increments per FAIL and saturates at 16'hFFFF.
REQ-028 CLR_FAIL simultaneous with a FAIL: result is FAIL_COUNT=1, FAIL_STICKY=1.
REQ-029 TEST_CYCLE change mid-cycle takes effect immediately on the strobe match.

Reset
REQ-030 RST asserted: timer, buffer/active expect and mask, CAPTURED, VALID, FAIL, FAIL_STICKY = 0; FAIL_COUNT = 0; all effective without a clock.
REQ-031 First strobe after RST release occurs no earlier than timer tick 0 of the first enabled cycle.
REQ-032 RST mid-cycle aborts any pending VALID/FAIL; no pulse after release without a new strobe.

Structure
REQ-033 Shared tester package holds EDGE_W=7, CYCLE_W=8 and FAIL_CNT_W=16; the pin driver uses the same constants.
REQ-034 One sub-module, cycle_timer (counter + wrap + strobe match), reusable by the driver side.
REQ-035 Buffer/active register pair, compare, and counters live in strobe_cmp_reg.

Verification
REQ-036 CYCLE_LENGTH_1=10, STROBE_EDGE_1=4, EXPECT=1, MASK=0, DUT_IN=1 -> VALID every 10 clocks, one clock after tick 4; FAIL=0.
REQ-037 Same setup, DUT_IN=0 -> FAIL with each VALID; FAIL_COUNT 1,2,3; FAIL_STICKY=1.
REQ-038 MASK=1, DUT_IN mismatched -> VALID pulses, FAIL=0, CAPTURED=0.
REQ-039 STROBE_EDGE_1=12, CYCLE_LENGTH_1=10 -> no VALID; TEST_CYCLE=1 with STROBE_EDGE_2=2 -> VALID after tick 2.
REQ-040 LOAD and TRANSFER high together -> active values unchanged; TRANSFER on the strobe tick -> old EXPECT compared.
REQ-041 FAIL_COUNT preset to 16'hFFFF by fails -> stays 16'hFFFF; CLR_FAIL with a fail -> count 1; RST mid-cycle -> all outputs 0 asynchronously.
